frame_mem_arbiter: RTL and testbench

- Shares one single-port synchronous frame memory (1024x768, 12-bit RGB) between the VGA pixel fetch path and two draw requesters (wr0: background/game logic, wr1: mouse/sprite overlay).
- VGA reads have absolute priority. Writers share the remaining cycles round-robin, with an optional locked burst mode.
- Sits between the timing/draw pipeline and the frame BRAM inside vga_example.

---
 rtl/frame_mem_arbiter.sv | 165 ++++++++++++++++
 tb/tb_frame_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_mem_arbiter.sv
// frame_mem_arbiter
//   Shares one single-port synchronous frame memory between the VGA pixel
//   fetch path and two draw requesters (wr0: background/game, wr1: overlay).
//   VGA reads always win; writers share the leftover cycles round-robin, and
//   a writer holding wrN_lock may own a burst of up to BURST_MAX grants.
//
// Handshake: a writer raises wrN_req with addr/data/lock stable and holds
//   them until it sees wrN_gnt=1 in the same cycle. The transfer happens on
//   the clock edge that ends that cycle. At that edge the writer either
//   presents its next item or drops req. wrN_gnt is combinational.
//
// Ports:
//   clk, rst                    pixel clock, synchronous active-high reset
//   vga_req/vga_addr            one read per cycle, no backpressure
//   vga_data/vga_valid          read pixel, three cycles after vga_req
//   wrN_req/lock/addr/data      writer request, burst-lock request, payload
//   wrN_gnt                     write accepted this cycle
//   mem_en/we/addr/wdata        registered memory command
//   mem_rdata                   memory read data, one cycle after mem_en
//   err_oob                     sticky out-of-range write flag
//   state_dbg                   FSM state (0 IDLE, 1 OWN0, 2 OWN1)
module frame_mem_arbiter #(
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 12,
    parameter int MEM_DEPTH = 786432,
    parameter int BURST_MAX = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              wr0_req,
    input  logic              wr0_lock,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    output logic              wr0_gnt,
    input  logic              wr1_req,
    input  logic              wr1_lock,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    output logic              wr1_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err_oob,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST_MAX);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(MEM_DEPTH);

    state_t            state;
    logic              rr_ptr;      // 0 favours wr0 when both request
    logic [CNT_W-1:0]  burst_cnt;
    logic              rd_p1, rd_p2; // read-request delay line feeding vga_valid

    logic              sel1;        // selected writer: 0 = wr0, 1 = wr1
    logic              g_req, g_lock, g_oob, gnt_any;
    logic [ADDR_W-1:0] g_addr;
    logic [DATA_W-1:0] g_data;
    logic [CNT_W-1:0]  cnt_next;

    // Owner is pinned during a burst; otherwise a lone requester wins and
    // contention is settled by the round-robin pointer.
    always_comb begin
        sel1 = 1'b0;
        case (state)
            OWN0:    sel1 = 1'b0;
            OWN1:    sel1 = 1'b1;
            default: sel1 = (wr0_req && wr1_req) ? rr_ptr : wr1_req;
        endcase
    end

    assign g_req    = sel1 ? wr1_req  : wr0_req;
    assign g_lock   = sel1 ? wr1_lock : wr0_lock;
    assign g_addr   = sel1 ? wr1_addr : wr0_addr;
    assign g_data   = sel1 ? wr1_data : wr0_data;
    assign g_oob    = {1'b0, g_addr} >= DEPTH_L;
    assign gnt_any  = g_req && !vga_req;
    assign wr0_gnt  = gnt_any && !sel1;
    assign wr1_gnt  = gnt_any && sel1;
    assign cnt_next = burst_cnt + CNT_W'(1);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            burst_cnt <= '0;
            rd_p1     <= 1'b0;
            rd_p2     <= 1'b0;
            vga_valid <= 1'b0;
            vga_data  <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err_oob   <= 1'b0;
        end else begin
            // Read return path: command register, memory, output register.
            rd_p1     <= vga_req;
            rd_p2     <= rd_p1;
            vga_valid <= rd_p2;
            if (rd_p2) begin
                vga_data <= mem_rdata;
            end

            // Out-of-range writes are granted so the requester moves on,
            // but never reach the memory.
            if (vga_req) begin
                mem_en   <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= vga_addr;
            end else if (gnt_any && !g_oob) begin
                mem_en    <= 1'b1;
                mem_we    <= 1'b1;
                mem_addr  <= g_addr;
                mem_wdata <= g_data;
            end else begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end

            if (gnt_any && g_oob) begin
                err_oob <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        rr_ptr <= !sel1;
                        if (g_lock && BURST_MAX > 1) begin
                            state     <= sel1 ? OWN1 : OWN0;
                            burst_cnt <= CNT_W'(1);
                        end
                    end
                end
                OWN0, OWN1: begin
                    // A VGA cycle stalls the burst without ending it.
                    if (!vga_req) begin
                        if (!g_req || !g_lock || cnt_next == CNT_MAX) begin
                            state     <= IDLE;
                            rr_ptr    <= !sel1;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= cnt_next;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_mem_arbiter.sv
module tb_frame_mem_arbiter;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 12;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              vga_req;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_valid;
  logic              wr0_req, wr0_lock, wr0_gnt;
  logic [ADDR_W-1:0] wr0_addr;
  logic [DATA_W-1:0] wr0_data;
  logic              wr1_req, wr1_lock, wr1_gnt;
  logic [ADDR_W-1:0] wr1_addr;
  logic [DATA_W-1:0] wr1_data;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              err_oob;
  logic [1:0]        state_dbg;

  frame_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_data(vga_data), .vga_valid(vga_valid),
    .wr0_req(wr0_req), .wr0_lock(wr0_lock), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_lock(wr1_lock), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_oob(err_oob), .state_dbg(state_dbg)
  );

  // ---------------- clock / memory model ----------------
  always #5 clk = ~clk;

  // Synchronous memory whose contents equal the low address bits.
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem_addr[DATA_W-1:0];
  end

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              lock;
  } wr_item_t;

  wr_item_t                 w_q0[$];
  wr_item_t                 w_q1[$];
  logic [DATA_W-1:0]        rd_exp_q[$];
  logic [ADDR_W+DATA_W-1:0] wr_exp_q[$];
  logic                     gnt_exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  logic g0_s = 1'b0;
  logic g1_s = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0h with nothing expected at %0t", name, act, $time);
  endtask

  function automatic int pending();
    return w_q0.size() + w_q1.size() + rd_exp_q.size() + wr_exp_q.size() + gnt_exp_q.size();
  endfunction

  task automatic drain();
    int k = 0;
    while (pending() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_pending", 32'(pending()), 32'd0);
  endtask

  task automatic exp_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic who);
    gnt_exp_q.push_back(who);
    wr_exp_q.push_back({a, d});
  endtask

  // ---------------- writer drivers ----------------
  // Each writer presents the front of its queue and advances after a grant.
  always @(negedge clk) begin
    g0_s <= rst ? 1'b0 : wr0_gnt;
    g1_s <= rst ? 1'b0 : wr1_gnt;
  end

  initial begin
    wr0_req = 1'b0; wr0_lock = 1'b0; wr0_addr = '0; wr0_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        w_q0.delete();
        wr0_req = 1'b0; wr0_lock = 1'b0;
      end else begin
        if (g0_s && w_q0.size() > 0) void'(w_q0.pop_front());
        if (w_q0.size() > 0) begin
          wr0_req = 1'b1;
          {wr0_addr, wr0_data, wr0_lock} = w_q0[0];
        end else begin
          wr0_req = 1'b0; wr0_lock = 1'b0;
        end
      end
    end
  end

  initial begin
    wr1_req = 1'b0; wr1_lock = 1'b0; wr1_addr = '0; wr1_data = '0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        w_q1.delete();
        wr1_req = 1'b0; wr1_lock = 1'b0;
      end else begin
        if (g1_s && w_q1.size() > 0) void'(w_q1.pop_front());
        if (w_q1.size() > 0) begin
          wr1_req = 1'b1;
          {wr1_addr, wr1_data, wr1_lock} = w_q1[0];
        end else begin
          wr1_req = 1'b0; wr1_lock = 1'b0;
        end
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (!rst && vga_valid) begin
      if (rd_exp_q.size() == 0) fail_unexpected("rd_unexpected", 32'(vga_data));
      else check("rd_data", 32'(vga_data), 32'(rd_exp_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!rst && mem_en && mem_we) begin
      if (wr_exp_q.size() == 0) fail_unexpected("wr_unexpected", {mem_addr, mem_wdata});
      else check("wr_addr_data", {mem_addr, mem_wdata}, wr_exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && (wr0_gnt || wr1_gnt)) begin
      check("gnt_onehot", 32'(wr0_gnt && wr1_gnt), 32'd0);
      if (gnt_exp_q.size() == 0) fail_unexpected("gnt_unexpected", {30'd0, wr1_gnt, wr0_gnt});
      else check("gnt_who", 32'(wr1_gnt), 32'(gnt_exp_q.pop_front()));
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    vga_req = 1'b0;
    vga_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_vga_valid", 32'(vga_valid), 32'd0);
    check("rst_vga_data", 32'(vga_data), 32'd0);
    check("rst_err_oob", 32'(err_oob), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    rst = 1'b0;

    // Four back-to-back reads; pixels return in cycles 3..6.
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i < 4) begin
        vga_req = 1'b1;
        vga_addr = ADDR_W'(i);
        rd_exp_q.push_back(DATA_W'(i));
      end else begin
        vga_req = 1'b0;
      end
      @(negedge clk);
      check("t1_vga_valid_timing", 32'(vga_valid), 32'(i >= 3 && i <= 6));
    end
    drain();

    // Contention without lock alternates wr0, wr1, wr0, wr1.
    @(negedge clk);
    w_q0.push_back('{20'h00010, 12'hA00, 1'b0});
    w_q0.push_back('{20'h00011, 12'hA01, 1'b0});
    w_q1.push_back('{20'h00020, 12'hB00, 1'b0});
    w_q1.push_back('{20'h00021, 12'hB01, 1'b0});
    exp_write(20'h00010, 12'hA00, 1'b0);
    exp_write(20'h00020, 12'hB00, 1'b1);
    exp_write(20'h00011, 12'hA01, 1'b0);
    exp_write(20'h00021, 12'hB01, 1'b1);
    drain();

    // wr0 stalled by five VGA cycles, granted once vga_req drops.
    @(negedge clk);
    w_q0.push_back('{20'h00030, 12'hC00, 1'b0});
    exp_write(20'h00030, 12'hC00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vga_req = 1'b1;
      vga_addr = ADDR_W'(100 + i);
      rd_exp_q.push_back(DATA_W'(100 + i));
      @(negedge clk);
      check("t3_stall_gnt", 32'(wr0_gnt), 32'd0);
    end
    @(posedge clk); #1;
    vga_req = 1'b0;
    @(negedge clk);
    check("t3_gnt_after_stall", 32'(wr0_gnt), 32'd1);
    drain();

    // Out-of-range write from wr1: granted, suppressed, flag sticks.
    @(negedge clk);
    w_q1.push_back('{20'd786432, 12'h5A5, 1'b0});
    gnt_exp_q.push_back(1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    check("t5_oob_gnt", 32'(wr1_gnt), 32'd1);
    @(negedge clk);
    check("t5_oob_mem_en", 32'(mem_en), 32'd0);
    check("t5_oob_mem_we", 32'(mem_we), 32'd0);
    check("t5_oob_err", 32'(err_oob), 32'd1);
    drain();

    // Locked burst: 16 wr0 grants, then wr1, wr0, wr1.
    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      w_q0.push_back('{ADDR_W'(32'h100 + i), DATA_W'(32'h100 + i), (i < 16)});
    end
    for (int i = 0; i < 2; i++) begin
      w_q1.push_back('{ADDR_W'(32'h200 + i), DATA_W'(32'h200 + i), 1'b0});
    end
    for (int i = 0; i < 16; i++) exp_write(ADDR_W'(32'h100 + i), DATA_W'(32'h100 + i), 1'b0);
    exp_write(20'h00200, 12'h200, 1'b1);
    exp_write(20'h00110, 12'h110, 1'b0);
    exp_write(20'h00201, 12'h201, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    @(negedge clk);
    check("t4_state_own0", 32'(state_dbg), 32'd1);
    drain();
    check("t4_err_oob_sticky", 32'(err_oob), 32'd1);

    // Move the pointer to wr1 so the post-reset contention is meaningful.
    @(negedge clk);
    w_q0.push_back('{20'h00040, 12'hD00, 1'b0});
    exp_write(20'h00040, 12'hD00, 1'b0);
    drain();

    // Reset with two reads in flight.
    @(posedge clk); #1;
    vga_req = 1'b1; vga_addr = 20'd7;
    @(posedge clk); #1;
    vga_addr = 20'd8;
    @(posedge clk); #1;
    vga_req = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_valid_flushed", 32'(vga_valid), 32'd0);
    @(negedge clk);
    check("t6_valid_flushed2", 32'(vga_valid), 32'd0);
    rst = 1'b0;
    check("t6_state_idle", 32'(state_dbg), 32'd0);
    check("t6_err_cleared", 32'(err_oob), 32'd0);
    check("t6_mem_en", 32'(mem_en), 32'd0);
    @(negedge clk);
    check("t6_valid_after", 32'(vga_valid), 32'd0);
    w_q0.push_back('{20'h00050, 12'hE00, 1'b0});
    w_q1.push_back('{20'h00060, 12'hF00, 1'b0});
    exp_write(20'h00050, 12'hE00, 1'b0);
    exp_write(20'h00060, 12'hF00, 1'b1);
    drain();

    repeat (4) @(negedge clk);
    check("final_rd_q_empty", 32'(rd_exp_q.size()), 32'd0);
    check("final_wr_q_empty", 32'(wr_exp_q.size()), 32'd0);
    check("final_gnt_q_empty", 32'(gnt_exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
